matrix_result_streamer: RTL

MATRIX_RESULT_STREAMER -- requirements
Module: matrix_result_streamer

---
 rtl/matrix_result_streamer_pkg.sv | 10 +
 rtl/matrix_result_streamer_if.sv | 19 +
 rtl/matrix_result_streamer_result_skid_fifo.sv | 41 ++++
 rtl/matrix_result_streamer.sv | 89 ++++++++
 4 files changed

// File: rtl/matrix_result_streamer_pkg.sv
// matrix_result_streamer_pkg: shared state encoding, sizing constants and element-count helper
package matrix_result_streamer_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, FLUSH = 2'd2} state_t;
  localparam int ADDR_W_DEF = 16;
  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W = 16;
  function automatic logic [CNT_W-1:0] total_count(input logic [7:0] m, input logic [7:0] n);
    return CNT_W'(m) * CNT_W'(n);
  endfunction
endpackage

// File: rtl/matrix_result_streamer_if.sv
// matrix_result_streamer_if: start/size capture, C-buffer read port and result stream
interface matrix_result_streamer_if import matrix_result_streamer_pkg::*; #(parameter int ADDR_W = ADDR_W_DEF);
  logic start;
  logic [7:0] M_val;
  logic [7:0] N_val;
  logic c_rd_en;
  logic [ADDR_W-1:0] c_addr;
  logic [31:0] c_rd_data;
  logic out_valid;
  logic out_ready;
  logic [31:0] out_data;
  logic out_last;
  logic busy;
  logic done;
  modport master(output start, M_val, N_val, c_rd_data, out_ready,
                 input c_rd_en, c_addr, out_valid, out_data, out_last, busy, done);
  modport slave(input start, M_val, N_val, c_rd_data, out_ready,
                output c_rd_en, c_addr, out_valid, out_data, out_last, busy, done);
endinterface

// File: rtl/matrix_result_streamer_result_skid_fifo.sv
// result_skid_fifo: small synchronous FIFO absorbing read data while the stream is stalled
module result_skid_fifo import matrix_result_streamer_pkg::*; #(parameter int W = 32) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  logic [W-1:0] mem_q [FIFO_DEPTH];
  logic [W-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = din;
    wr_d = push ? wr_q + PW'(1) : wr_q;
    rd_d = pop ? rd_q + PW'(1) : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  assign dout = mem_q[rd_q];
  assign full = cnt_q == CW'(FIFO_DEPTH);
  assign empty = cnt_q == '0;
endmodule

// File: rtl/matrix_result_streamer.sv
// matrix_result_streamer: drains an MxN result buffer row-major onto a valid/ready stream
// with one-cycle read latency absorbed by a 2-entry skid FIFO.
module matrix_result_streamer import matrix_result_streamer_pkg::*; #(
  parameter int MAX_M = 100,
  parameter int MAX_N = 100,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic clk,
  input logic rst_n,
  matrix_result_streamer_if.slave bus
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] total_q, total_d, rd_idx_q, rd_idx_d, out_idx_q, out_idx_d, new_total;
  logic inflight_q, inflight_d, done_q, done_d;
  logic [7:0] m_eff, n_eff;
  logic [1:0] occ, load;
  logic fifo_full, fifo_empty, out_valid, out_last, pop, issue, accept;
  logic [31:0] head;
  assign m_eff = (bus.M_val > 8'(MAX_M)) ? 8'(MAX_M) : bus.M_val;
  assign n_eff = (bus.N_val > 8'(MAX_N)) ? 8'(MAX_N) : bus.N_val;
  assign new_total = total_count(m_eff, n_eff);
  assign out_valid = ~fifo_empty;
  assign out_last = out_valid && (out_idx_q == total_q - CNT_W'(1));
  assign pop = out_valid & bus.out_ready;
  // Count the beat leaving this cycle so a steady stream keeps one read per cycle.
  assign occ = fifo_full ? 2'd2 : {1'b0, ~fifo_empty};
  assign load = occ - {1'b0, pop} + {1'b0, inflight_q};
  assign issue = (state_q == STREAM) && (rd_idx_q < total_q) && (load < 2'd2);
  // A start landing on the done pulse must not re-arm the drain.
  assign accept = (state_q == IDLE) && bus.start && !done_q;
  always_comb begin
    state_d = state_q;
    total_d = total_q;
    rd_idx_d = rd_idx_q;
    out_idx_d = out_idx_q;
    inflight_d = issue;
    done_d = 1'b0;
    if (accept) begin
      total_d = new_total;
      rd_idx_d = '0;
      out_idx_d = '0;
      state_d = (new_total == '0) ? IDLE : STREAM;
      done_d = new_total == '0;
    end
    if (issue) begin
      rd_idx_d = rd_idx_q + CNT_W'(1);
      state_d = (rd_idx_q == total_q - CNT_W'(1)) ? FLUSH : state_d;
    end
    if (pop) out_idx_d = out_idx_q + CNT_W'(1);
    if (pop && out_last) begin
      state_d = IDLE;
      done_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      total_q <= '0;
      rd_idx_q <= '0;
      out_idx_q <= '0;
      inflight_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      rd_idx_q <= rd_idx_d;
      out_idx_q <= out_idx_d;
      inflight_q <= inflight_d;
      done_q <= done_d;
    end
  end
  result_skid_fifo #(.W(32)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(inflight_q),
    .pop(pop),
    .din(bus.c_rd_data),
    .dout(head),
    .full(fifo_full),
    .empty(fifo_empty)
  );
  assign bus.c_rd_en = issue;
  assign bus.c_addr = ADDR_W'(rd_idx_q);
  assign bus.out_valid = out_valid;
  assign bus.out_data = out_valid ? head : '0;
  assign bus.out_last = out_last;
  assign bus.busy = state_q != IDLE;
  assign bus.done = done_q;
endmodule
